// File: rtl/frame_fcs_checker.sv
// Streaming Ethernet FCS checker: CRC-32 over each axiiv-framed burst, length and
// alignment screening, a held per-frame verdict and saturating good/bad counters.
module frame_fcs_checker #(
    parameter int unsigned DATA_W    = 2,
    parameter int unsigned MIN_BYTES = 64,
    parameter int unsigned MAX_BYTES = 1522,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           axiiv,
    input  logic [DATA_W-1:0]              axiid,
    input  logic                           clear_stats,
    output logic                           done,
    output logic                           kill,
    output logic                           result_valid,
    output logic                           len_err,
    output logic                           align_err,
    output logic [31:0]                    crc_out,
    output logic [$clog2(MAX_BYTES+2)-1:0] frame_bytes,
    output logic [CNT_W-1:0]               good_cnt,
    output logic [CNT_W-1:0]               bad_cnt
);
    localparam int unsigned       BYTE_W      = $clog2(MAX_BYTES + 2);
    localparam logic [31:0]       CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0]       CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0]       CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [BYTE_W-1:0] BYTE_SAT    = BYTE_W'(MAX_BYTES + 1);

    // DISARMED also stands in for "previous beat valid" being unknown after reset.
    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_FRAME    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         crc_q, crc_d;
    logic [2:0]          sub_q, sub_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic                done_q, done_d;
    logic                kill_q, kill_d;
    logic                rv_q, rv_d;
    logic                len_err_q, len_err_d;
    logic                align_err_q, align_err_d;
    logic [31:0]         crc_out_q, crc_out_d;
    logic [BYTE_W-1:0]   frame_bytes_q, frame_bytes_d;
    logic [CNT_W-1:0]    good_q, good_d;
    logic [CNT_W-1:0]    bad_q, bad_d;

    logic                beat;
    logic                frame_start;
    logic                frame_end;
    logic [3:0]          bit_sum;
    logic                v_crc_ok;
    logic                v_len;
    logic                v_align;
    logic                v_kill;

    // Reflected CRC-32, one input bit per iteration, bit 0 first on the wire.
    function automatic logic [31:0] crc_update(input logic [31:0] c_in,
                                               input logic [DATA_W-1:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            fb = c[0] ^ d[i];
            c  = c >> 1;
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        sub_d         = sub_q;
        byte_d        = byte_q;
        done_d        = done_q;
        kill_d        = kill_q;
        len_err_d     = len_err_q;
        align_err_d   = align_err_q;
        crc_out_d     = crc_out_q;
        frame_bytes_d = frame_bytes_q;
        good_d        = good_q;
        bad_d         = bad_q;
        beat          = 1'b0;
        frame_start   = 1'b0;
        frame_end     = 1'b0;

        case (state_q)
            ST_DISARMED: begin
                if (!axiiv) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (axiiv) begin
                    state_d     = ST_FRAME;
                    frame_start = 1'b1;
                    beat        = 1'b1;
                end
            end
            ST_FRAME: begin
                if (axiiv) begin
                    beat = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                    frame_end = 1'b1;
                end
            end
            default: begin
                state_d = ST_DISARMED;
            end
        endcase

        rv_d     = frame_end;
        bit_sum  = 4'({1'b0, sub_q}) + 4'(DATA_W);
        v_crc_ok = (crc_q == CRC_RESIDUE);
        v_align  = (sub_q != 3'd0);
        v_len    = (32'(byte_q) < MIN_BYTES) || (32'(byte_q) > MAX_BYTES);
        v_kill   = ~v_crc_ok | v_len | v_align;

        if (beat) begin
            crc_d = crc_update(crc_q, axiid);
            sub_d = bit_sum[2:0];
            if (bit_sum[3] && (byte_q != BYTE_SAT)) begin
                byte_d = byte_q + BYTE_W'(1);
            end
        end

        if (frame_start) begin
            done_d      = 1'b0;
            kill_d      = 1'b0;
            len_err_d   = 1'b0;
            align_err_d = 1'b0;
        end

        // Verdict edge: latch fields, bump a counter, rearm the CRC for the next frame.
        if (frame_end) begin
            done_d        = 1'b1;
            kill_d        = v_kill;
            len_err_d     = v_len;
            align_err_d   = v_align;
            crc_out_d     = ~crc_q;
            frame_bytes_d = byte_q;
            crc_d         = CRC_INIT;
            sub_d         = 3'd0;
            byte_d        = '0;
            if (v_kill) begin
                if (bad_q != {CNT_W{1'b1}}) begin
                    bad_d = bad_q + CNT_W'(1);
                end
            end else begin
                if (good_q != {CNT_W{1'b1}}) begin
                    good_d = good_q + CNT_W'(1);
                end
            end
        end

        if (clear_stats) begin
            good_d = '0;
            bad_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_DISARMED;
            crc_q         <= CRC_INIT;
            sub_q         <= 3'd0;
            byte_q        <= '0;
            done_q        <= 1'b0;
            kill_q        <= 1'b0;
            rv_q          <= 1'b0;
            len_err_q     <= 1'b0;
            align_err_q   <= 1'b0;
            crc_out_q     <= 32'd0;
            frame_bytes_q <= '0;
            good_q        <= '0;
            bad_q         <= '0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            sub_q         <= sub_d;
            byte_q        <= byte_d;
            done_q        <= done_d;
            kill_q        <= kill_d;
            rv_q          <= rv_d;
            len_err_q     <= len_err_d;
            align_err_q   <= align_err_d;
            crc_out_q     <= crc_out_d;
            frame_bytes_q <= frame_bytes_d;
            good_q        <= good_d;
            bad_q         <= bad_d;
        end
    end

    assign done         = done_q;
    assign kill         = kill_q;
    assign result_valid = rv_q;
    assign len_err      = len_err_q;
    assign align_err    = align_err_q;
    assign crc_out      = crc_out_q;
    assign frame_bytes  = frame_bytes_q;
    assign good_cnt     = good_q;
    assign bad_cnt      = bad_q;

endmodule

// File: tb/tb_frame_fcs_checker.sv
// Directed bench for frame_fcs_checker: dibit instances (MIN_BYTES=1 and defaults with
// 2-bit counters) share one stream; a byte-wide instance gets its own stream.
module tb_frame_fcs_checker;
    localparam int unsigned BW = $clog2(1522 + 2);
    localparam logic [31:0] GOOD_CRC_OUT = 32'h2144_DF1C;

    logic        clk = 1'b0;
    logic        rst;
    logic        v2;
    logic [1:0]  d2;
    logic        v8;
    logic [7:0]  d8;
    logic        clear_stats;

    logic a_done, a_kill, a_rv, a_len, a_align;
    logic [31:0] a_crc;
    logic [BW-1:0] a_bytes;
    logic [15:0] a_good, a_bad;

    logic b_done, b_kill, b_rv, b_len, b_align;
    logic [31:0] b_crc;
    logic [BW-1:0] b_bytes;
    logic [1:0]  b_good, b_bad;

    logic c_done, c_kill, c_rv, c_len, c_align;
    logic [31:0] c_crc;
    logic [BW-1:0] c_bytes;
    logic [15:0] c_good, c_bad;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] fbuf [0:79];

    always #5 clk = ~clk;

    frame_fcs_checker #(.DATA_W(2), .MIN_BYTES(1)) u_dut_a (
        .clk(clk), .rst(rst), .axiiv(v2), .axiid(d2), .clear_stats(clear_stats),
        .done(a_done), .kill(a_kill), .result_valid(a_rv), .len_err(a_len),
        .align_err(a_align), .crc_out(a_crc), .frame_bytes(a_bytes),
        .good_cnt(a_good), .bad_cnt(a_bad));

    frame_fcs_checker #(.CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .axiiv(v2), .axiid(d2), .clear_stats(clear_stats),
        .done(b_done), .kill(b_kill), .result_valid(b_rv), .len_err(b_len),
        .align_err(b_align), .crc_out(b_crc), .frame_bytes(b_bytes),
        .good_cnt(b_good), .bad_cnt(b_bad));

    frame_fcs_checker #(.DATA_W(8), .MIN_BYTES(1)) u_dut_c (
        .clk(clk), .rst(rst), .axiiv(v8), .axiid(d8), .clear_stats(clear_stats),
        .done(c_done), .kill(c_kill), .result_valid(c_rv), .len_err(c_len),
        .align_err(c_align), .crc_out(c_crc), .frame_bytes(c_bytes),
        .good_cnt(c_good), .bad_cnt(c_bad));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic rv, input logic dn, input logic kl,
                         input logic le, input logic ae, input int nb, input int gc, input int bc);
        check_eq({tag, ".a.rv"},    32'(a_rv),    32'(rv));
        check_eq({tag, ".a.done"},  32'(a_done),  32'(dn));
        check_eq({tag, ".a.kill"},  32'(a_kill),  32'(kl));
        check_eq({tag, ".a.len"},   32'(a_len),   32'(le));
        check_eq({tag, ".a.align"}, 32'(a_align), 32'(ae));
        check_eq({tag, ".a.bytes"}, 32'(a_bytes), nb);
        check_eq({tag, ".a.good"},  32'(a_good),  gc);
        check_eq({tag, ".a.bad"},   32'(a_bad),   bc);
    endtask

    task automatic chk_b(input string tag, input logic kl, input logic le, input logic ae,
                         input int nb, input int gc, input int bc);
        check_eq({tag, ".b.kill"},  32'(b_kill),  32'(kl));
        check_eq({tag, ".b.len"},   32'(b_len),   32'(le));
        check_eq({tag, ".b.align"}, 32'(b_align), 32'(ae));
        check_eq({tag, ".b.bytes"}, 32'(b_bytes), nb);
        check_eq({tag, ".b.good"},  32'(b_good),  gc);
        check_eq({tag, ".b.bad"},   32'(b_bad),   bc);
    endtask

    task automatic chk_c(input string tag, input logic rv, input logic dn, input logic kl,
                         input int nb, input int gc, input int bc);
        check_eq({tag, ".c.rv"},    32'(c_rv),    32'(rv));
        check_eq({tag, ".c.done"},  32'(c_done),  32'(dn));
        check_eq({tag, ".c.kill"},  32'(c_kill),  32'(kl));
        check_eq({tag, ".c.bytes"}, 32'(c_bytes), nb);
        check_eq({tag, ".c.good"},  32'(c_good),  gc);
        check_eq({tag, ".c.bad"},   32'(c_bad),   bc);
    endtask

    // Reference CRC register after n bytes of fbuf, used only to build FCS trailers.
    function automatic logic [31:0] crc_reg(input int n);
        logic [31:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            b = fbuf[i];
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[k];
                c  = (c >> 1) ^ (fb ? 32'hEDB8_8320 : 32'h0);
            end
        end
        return c;
    endfunction

    function automatic logic [1:0] dibit_at(input int k);
        logic [7:0] b;
        b = fbuf[k/4];
        return b[(k%4)*2 +: 2];
    endfunction

    task automatic load_check9();
        for (int i = 0; i < 9; i++) fbuf[i] = 8'(8'h31 + i);
    endtask

    task automatic load_f13();
        load_check9();
        fbuf[9] = 8'h26; fbuf[10] = 8'h39; fbuf[11] = 8'hF4; fbuf[12] = 8'hCB;
    endtask

    task automatic load_fcs(input int n);
        logic [31:0] fcs;
        for (int i = 0; i < n; i++) fbuf[i] = 8'(i * 7 + 3);
        fcs = ~crc_reg(n);
        fbuf[n] = fcs[7:0]; fbuf[n+1] = fcs[15:8]; fbuf[n+2] = fcs[23:16]; fbuf[n+3] = fcs[31:24];
    endtask

    // Called at a negedge; drives one dibit per cycle, returns at the negedge after the last.
    task automatic send2(input int nbytes, input int extra, input int skip);
        for (int k = skip; k < nbytes * 4 + extra; k++) begin
            v2 = 1'b1;
            d2 = (k < nbytes * 4) ? dibit_at(k) : 2'b00;
            @(negedge clk);
        end
    endtask

    task automatic send8(input int nbytes, input int skip);
        for (int i = skip; i < nbytes; i++) begin
            v8 = 1'b1;
            d8 = fbuf[i];
            @(negedge clk);
        end
    endtask

    task automatic idle2();
        v2 = 1'b0; d2 = 2'b00;
        @(negedge clk);
    endtask

    task automatic idle8();
        v8 = 1'b0; d8 = 8'h00;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; v2 = 1'b0; d2 = 2'b00; v8 = 1'b0; d8 = 8'h00; clear_stats = 1'b0;
        repeat (2) @(negedge clk);
        chk_a("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("reset.a.crc", a_crc, 32'h0);
        chk_c("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // "123456789" without FCS: standard check value, bad frame.
        load_check9(); send2(9, 0, 0); idle2();
        chk_a("chk9", 1, 1, 1, 0, 0, 9, 0, 1);
        check_eq("chk9.a.crc", a_crc, 32'hCBF4_3926);
        chk_b("chk9", 1, 1, 0, 9, 0, 1);
        @(negedge clk);
        check_eq("chk9.a.rv_pulse", 32'(a_rv), 32'd0);
        check_eq("chk9.a.done_held", 32'(a_done), 32'd1);

        // Same bytes plus FCS: good frame; b rejects on length.
        load_f13(); send2(13, 0, 0); idle2();
        chk_a("f13", 1, 1, 0, 0, 0, 13, 1, 1);
        check_eq("f13.a.crc", a_crc, GOOD_CRC_OUT);
        chk_b("f13", 1, 1, 0, 13, 0, 2);
        @(negedge clk);
        check_eq("f13.a.rv_pulse", 32'(a_rv), 32'd0);

        // One trailing dibit: misaligned.
        send2(13, 1, 0); idle2();
        chk_a("align", 1, 1, 1, 0, 1, 13, 1, 2);
        chk_b("align", 1, 1, 1, 13, 0, 3);

        // 60-byte valid FCS: a accepts, b runt with saturated bad counter.
        load_fcs(56); send2(60, 0, 0); idle2();
        chk_a("f60", 1, 1, 0, 0, 0, 60, 2, 2);
        chk_b("f60", 1, 1, 0, 60, 0, 3);

        load_fcs(60); send2(64, 0, 0); idle2();
        chk_a("f64", 1, 1, 0, 0, 0, 64, 3, 2);
        chk_b("f64", 0, 0, 0, 64, 1, 3);
        check_eq("f64.b.crc", b_crc, GOOD_CRC_OUT);

        // Two frames separated by one idle cycle.
        load_f13(); send2(13, 0, 0);
        v2 = 1'b0; d2 = 2'b00;
        @(negedge clk);
        chk_a("gap1", 1, 1, 0, 0, 0, 13, 4, 2);
        v2 = 1'b1; d2 = dibit_at(0);
        @(negedge clk);
        chk_a("gap_start", 0, 0, 0, 0, 0, 13, 4, 2);
        check_eq("gap_start.a.crc_hold", a_crc, GOOD_CRC_OUT);
        send2(13, 0, 1); idle2();
        chk_a("gap2", 1, 1, 0, 0, 0, 13, 5, 2);
        chk_b("gap2", 1, 1, 0, 13, 1, 3);

        // Statistics clear, alone and coincident with a verdict.
        clear_stats = 1'b1; @(negedge clk); clear_stats = 1'b0;
        check_eq("clr.a.good", 32'(a_good), 32'd0);
        check_eq("clr.b.bad", 32'(b_bad), 32'd0);
        send2(13, 0, 0);
        v2 = 1'b0; clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        chk_a("clr_vrd", 1, 1, 0, 0, 0, 13, 0, 0);
        chk_b("clr_vrd", 1, 1, 0, 13, 0, 0);
        send2(13, 0, 0); idle2();
        chk_a("post_clr", 1, 1, 0, 0, 0, 13, 1, 0);
        chk_b("post_clr", 1, 1, 0, 13, 0, 1);

        // Runt under 32 bits.
        fbuf[0] = 8'hAA; fbuf[1] = 8'h55;
        send2(2, 0, 0); idle2();
        chk_a("runt", 1, 1, 1, 0, 0, 2, 1, 1);
        chk_b("runt", 1, 1, 0, 2, 0, 2);

        // Byte-wide instance.
        load_check9(); send8(9, 0); idle8();
        chk_c("c_chk9", 1, 1, 1, 9, 0, 1);
        check_eq("c_chk9.c.crc", c_crc, 32'hCBF4_3926);
        load_f13(); send8(13, 0); idle8();
        chk_c("c_f13", 1, 1, 0, 13, 1, 1);
        check_eq("c_f13.c.crc", c_crc, GOOD_CRC_OUT);
        check_eq("c_f13.c.align", 32'(c_align), 32'd0);
        send8(13, 0);
        v8 = 1'b0; @(negedge clk);
        chk_c("c_gap1", 1, 1, 0, 13, 2, 1);
        v8 = 1'b1; d8 = fbuf[0]; @(negedge clk);
        chk_c("c_gap_start", 0, 0, 0, 13, 2, 1);
        send8(13, 1); idle8();
        chk_c("c_gap2", 1, 1, 0, 13, 3, 1);

        // Reset asserted mid-frame, released with both streams still valid.
        load_f13();
        for (int k = 0; k < 52; k++) begin
            if (k == 8) rst = 1'b1;
            if (k == 12) rst = 1'b0;
            v2 = 1'b1; d2 = dibit_at(k);
            if (k < 13) begin v8 = 1'b1; d8 = fbuf[k]; end
            else begin v8 = 1'b0; d8 = 8'h00; end
            @(negedge clk);
        end
        idle2();
        chk_a("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
        chk_c("rst_mid", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_eq("rst_mid.a.rv_late", 32'(a_rv), 32'd0);
        send2(13, 0, 0); idle2();
        chk_a("rst_next", 1, 1, 0, 0, 0, 13, 1, 0);
        send8(13, 0); idle8();
        chk_c("rst_next", 1, 1, 0, 13, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/frame_fcs_checker.md
FRAME_FCS_CHECKER -- requirements
Module: frame_fcs_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 2, giving bits per input beat; legal values 1, 2, 4 and 8.
REQ-002 SHALL have parameter MIN_BYTES, default 64, giving the minimum legal frame length in bytes, FCS included.
REQ-003 SHALL have parameter MAX_BYTES, default 1522, giving the maximum legal frame length in bytes, FCS included.
REQ-004 SHALL have parameter CNT_W, default 16, giving the width of the statistics counters.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port axiiv, input, 1 bit: beat valid; high for the whole frame, low between frames.
REQ-008 SHALL have port axiid, input, DATA_W bits: beat data; bit 0 is the earliest on-wire bit.
REQ-009 SHALL have port clear_stats, input, 1 bit: synchronous clear of good_cnt and bad_cnt.
REQ-010 SHALL have port done, output, 1 bit: level; a frame verdict is held.
REQ-011 SHALL have port kill, output, 1 bit: level; the held verdict is "discard frame".
REQ-012 SHALL have port result_valid, output, 1 bit: one-cycle pulse marking a new verdict.
REQ-013 SHALL have ports len_err and align_err, output, 1 bit each: the held length and alignment error flags.
REQ-014 SHALL have port crc_out, output, 32 bits: the final register value of the last frame, complemented.
REQ-015 SHALL have port frame_bytes, output, $clog2(MAX_BYTES+2) bits: the byte count of the last frame.
REQ-016 SHALL have ports good_cnt and bad_cnt, output, CNT_W bits each: saturating frame counters.

Function
REQ-017 SHALL compute CRC-32 reflected: register c is initialised to 0xFFFFFFFF; for each input bit b, processed LSB-first within each beat, fb = c[0]^b, then c = c>>1, then c ^= 0xEDB88320 if fb; DATA_W bits are consumed per valid cycle in a single clock.
REQ-018 SHALL detect frame start as axiiv high while the previous-cycle axiiv (prev_v) is low, and frame end as axiiv low while prev_v is high.
REQ-019 SHALL, after reset, hold the block disarmed until axiiv has been sampled low for at least one cycle, and SHALL ignore any beats while disarmed, so that a partial frame is never checked.
REQ-020 SHALL count bits per frame and derive frame_bytes = bits/8, with the internal byte counter saturating at MAX_BYTES+1.
REQ-021 SHALL, at the end cycle E, register the verdict so that it is visible in cycle E+1, with result_valid high for E+1 only.
REQ-022 SHALL set the verdict fields as follows: crc_ok = (c == 0xDEBB20E3); align_err = (bit count mod 8 != 0); len_err = (bytes < MIN_BYTES or bytes > MAX_BYTES).
REQ-023 SHALL drive kill = ~crc_ok | len_err | align_err, and SHALL drive done = 1 together with the verdict.
REQ-024 SHALL drive crc_out = ~c captured at E, before the register is reinitialised.
REQ-025 SHALL reinitialise c to 0xFFFFFFFF and the bit counter to 0 on the edge ending E.
REQ-026 SHALL clear done, kill, len_err and align_err at the edge following a frame-start cycle, and SHALL leave crc_out and frame_bytes holding their old values.
REQ-027 SHALL, for a one-cycle gap (end then start on the next cycle), complete the verdict of the first frame with a result_valid pulse in the start cycle, then clear the verdict on the following edge.
REQ-028 SHALL increment good_cnt (if kill=0) or bad_cnt (if kill=1) on the verdict edge, with each counter saturating at all-ones.
REQ-029 SHALL give clear_stats priority over a simultaneous increment, leaving the result at 0.
REQ-030 SHALL count a frame shorter than 32 bits as bad, with len_err set when MIN_BYTES >= 4.

Reset
REQ-031 SHALL, on rst high and asynchronously, drive done=0, kill=0, result_valid=0, len_err=0, align_err=0, crc_out=0, frame_bytes=0, good_cnt=0, bad_cnt=0, c=0xFFFFFFFF, prev_v=0 and the block disarmed.
REQ-032 SHALL, on reset asserted mid-frame, discard that frame entirely; no verdict and no counter change result from it.

Verification
REQ-033 SHALL pass this scenario: MIN_BYTES=1, DATA_W=2, bytes "123456789" with no FCS -> crc_out=0xCBF43926, kill=1, bad_cnt=1, frame_bytes=9.
REQ-034 SHALL pass this scenario: the same bytes followed by 26 39 F4 CB -> result_valid for one cycle at E+1, kill=0, done=1, good_cnt=1, frame_bytes=13.
REQ-035 SHALL pass this scenario: defaults, a valid-FCS 60-byte frame -> len_err=1, kill=1; a valid-FCS 64-byte frame -> kill=0.
REQ-036 SHALL pass this scenario: a 13-byte good frame plus one extra dibit (MIN_BYTES=1) -> align_err=1, kill=1.
REQ-037 SHALL pass this scenario: two good frames separated by a single idle cycle -> two result_valid pulses, good_cnt=2, done low in the cycle after the second start.
REQ-038 SHALL pass this scenario: rst released with axiiv already high mid-frame -> no verdict for that frame; the next full frame is checked normally; repeat the suite with DATA_W=8.
